// File: rtl/parking_pkg.sv
// Shared encodings and types for the parking access controller and its floor bookkeeping.
package parking_pkg;

  localparam int unsigned ID_W        = 28;
  localparam int unsigned MODE_W      = 2;
  localparam logic [19:0] ID_PREFIX   = 20'h20230;

  typedef enum logic [1:0] {
    MODE_ENTER    = 2'd0,
    MODE_EXIT     = 2'd1,
    MODE_RESTRICT = 2'd2,
    MODE_RSVD     = 2'd3
  } mode_e;

  typedef enum logic [1:0] {
    ACT_NONE   = 2'd0,
    ACT_ALT    = 2'd1,
    ACT_CHOSEN = 2'd2,
    ACT_EXIT   = 2'd3
  } action_e;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_CHECK     = 3'd1,
    ST_OFFER_ALT = 3'd2,
    ST_COMMIT    = 3'd3,
    ST_GATE      = 3'd4,
    ST_DENY      = 3'd5
  } state_e;

  // Request presented to the floor logic while a transaction is in flight.
  typedef struct packed {
    logic [ID_W-1:0]   id;
    logic [MODE_W-1:0] mode;
    logic              flr;
  } req_t;

endpackage

// File: rtl/gate_timer.sv
// Loadable saturating down-counter; done_o is high while the count is at or below one,
// i.e. the current cycle is the last one of the loaded interval.
module gate_timer #(
  parameter int unsigned W = 5
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         dec_i,
  output logic         done_o
);

  logic [W-1:0] count_q, count_d;
  logic         done_q;

  always_comb begin
    count_d = count_q;
    if (load_i) begin
      count_d = load_val_i;
    end else if (dec_i && (count_q != '0)) begin
      count_d = count_q - W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
      done_q  <= 1'b1;
    end else begin
      count_q <= count_d;
      done_q  <= (count_d <= W'(1));
    end
  end

  assign done_o = done_q;

endmodule

// File: rtl/gate_access_ctrl.sv
// Parking gate sequencer: captures a keypad request, decides grant/alternative/deny,
// commits the action to the floor logic and times the barrier. Optional event counters
// are enabled with GATE_ACCESS_EVENT_CNT_EN.
module gate_access_ctrl
  import parking_pkg::*;
#(
  parameter int unsigned GATE_OPEN_CYCLES   = 8,
  parameter int unsigned ALT_TIMEOUT_CYCLES = 16
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic [ID_W-1:0]   id_in,
  input  logic              id_strobe,
  input  logic [MODE_W-1:0] mode_in,
  input  logic              flr_sel,
  input  logic              accept_alt,
  input  logic              reject,
  input  logic              id_valid,
  input  logic              id_special,
  input  logic              adminId_valid,
  input  logic              chosen_flr_full,
  input  logic              alternative_flr_full,
  output logic [ID_W-1:0]   ID,
  output logic [MODE_W-1:0] MODE,
  output logic              chosen_flr,
  output logic [1:0]        action_taken,
  output logic              gate_open,
  output logic              prompt_alt,
  output logic              deny,
  output logic              busy
`ifdef GATE_ACCESS_EVENT_CNT_EN
  ,
  output logic [7:0]        grant_cnt,
  output logic [7:0]        deny_cnt
`endif
);

  localparam int unsigned TMR_MAX = (GATE_OPEN_CYCLES > ALT_TIMEOUT_CYCLES) ?
                                    GATE_OPEN_CYCLES : ALT_TIMEOUT_CYCLES;
  localparam int unsigned TMR_W   = $clog2(TMR_MAX + 1);

  state_e           state_q, state_d;
  req_t             req_q, req_d;
  action_e          act_d;
  logic             force_flr0;
  logic [1:0]       action_q, action_d;
  logic             gate_q, gate_d;
  logic             prompt_q, prompt_d;
  logic             deny_q, deny_d;
  logic             busy_q, busy_d;
  logic             tmr_load, tmr_dec, tmr_done;
  logic [TMR_W-1:0] tmr_val;

  gate_timer #(.W(TMR_W)) u_timer (
    .clk        (CLK),
    .rst_n      (RST_N),
    .load_i     (tmr_load),
    .load_val_i (tmr_val),
    .dec_i      (tmr_dec),
    .done_o     (tmr_done)
  );

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Flags from the floor logic are only consulted in CHECK.
  always_comb begin
    state_d    = state_q;
    act_d      = ACT_NONE;
    force_flr0 = 1'b0;
    case (state_q)
      ST_IDLE: if (id_strobe) state_d = ST_CHECK;
      ST_CHECK: begin
        if (adminId_valid) begin
          state_d = ST_GATE;
        end else if ((req_q.mode == MODE_ENTER) && id_special) begin
          force_flr0 = 1'b1;
          act_d      = ACT_CHOSEN;
          state_d    = ST_COMMIT;
        end else if ((req_q.mode == MODE_ENTER) && id_valid) begin
          if (!chosen_flr_full) begin
            act_d   = ACT_CHOSEN;
            state_d = ST_COMMIT;
          end else if (!alternative_flr_full) begin
            state_d = ST_OFFER_ALT;
          end else begin
            state_d = ST_DENY;
          end
        end else if ((req_q.mode == MODE_EXIT) && id_valid) begin
          act_d   = ACT_EXIT;
          state_d = ST_COMMIT;
        end else if ((req_q.mode == MODE_EXIT) && id_special) begin
          state_d = ST_GATE;
        end else begin
          state_d = ST_DENY;
        end
      end
      ST_OFFER_ALT: begin
        if (reject) begin
          state_d = ST_DENY;
        end else if (accept_alt) begin
          act_d   = ACT_ALT;
          state_d = ST_COMMIT;
        end else if (tmr_done) begin
          state_d = ST_DENY;
        end
      end
      ST_COMMIT: state_d = ST_GATE;
      ST_GATE:   if (tmr_done) state_d = ST_IDLE;
      ST_DENY:   state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // Outputs are registered from the next state so they line up with the state they describe.
  always_comb begin
    req_d = req_q;
    if ((state_q == ST_IDLE) && id_strobe) begin
      req_d.id   = id_in;
      req_d.mode = mode_in;
      req_d.flr  = flr_sel;
    end
    if (force_flr0) req_d.flr = 1'b0;
    action_d = 2'(act_d);
    gate_d   = (state_d == ST_GATE);
    prompt_d = (state_d == ST_OFFER_ALT);
    deny_d   = (state_d == ST_DENY);
    busy_d   = (state_d != ST_IDLE);
    tmr_load = (state_d != state_q) && ((state_d == ST_GATE) || (state_d == ST_OFFER_ALT));
    tmr_val  = (state_d == ST_GATE) ? TMR_W'(GATE_OPEN_CYCLES) : TMR_W'(ALT_TIMEOUT_CYCLES);
    tmr_dec  = (state_q == ST_GATE) || (state_q == ST_OFFER_ALT);
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      req_q    <= '0;
      action_q <= 2'd0;
      gate_q   <= 1'b0;
      prompt_q <= 1'b0;
      deny_q   <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      req_q    <= req_d;
      action_q <= action_d;
      gate_q   <= gate_d;
      prompt_q <= prompt_d;
      deny_q   <= deny_d;
      busy_q   <= busy_d;
    end
  end

  assign ID           = req_q.id;
  assign MODE         = req_q.mode;
  assign chosen_flr   = req_q.flr;
  assign action_taken = action_q;
  assign gate_open    = gate_q;
  assign prompt_alt   = prompt_q;
  assign deny         = deny_q;
  assign busy         = busy_q;

`ifdef GATE_ACCESS_EVENT_CNT_EN
  logic [7:0] grant_cnt_q, deny_cnt_q;

  // Saturating counts of GATE and DENY entries.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      grant_cnt_q <= 8'd0;
      deny_cnt_q  <= 8'd0;
    end else begin
      if ((state_d == ST_GATE) && (state_q != ST_GATE) && (grant_cnt_q != 8'hFF))
        grant_cnt_q <= grant_cnt_q + 8'd1;
      if ((state_d == ST_DENY) && (state_q != ST_DENY) && (deny_cnt_q != 8'hFF))
        deny_cnt_q <= deny_cnt_q + 8'd1;
    end
  end

  assign grant_cnt = grant_cnt_q;
  assign deny_cnt  = deny_cnt_q;
`endif

endmodule
